// File: rtl/tinysoc_pkg.sv
// Constants for the tiny 4-bit SoC.
// The run controller and the CPU top both use them.
package tinysoc_pkg;

  localparam int IMEM_WORDS = 8;
  localparam int QUINTET_W  = 5;
  localparam int INSTR_W    = 15;
  localparam int ADDR_W     = $clog2(IMEM_WORDS);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_HALT  = 3'd3,
    ST_STEP  = 3'd4
  } state_e;

endpackage

// File: rtl/quintet_assembler.sv
// Packs three 5-bit quintets into one 15-bit word.
// Issues a one-cycle instruction memory write per word.
module quintet_assembler
  import tinysoc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 acc_i,
  input  logic [QUINTET_W-1:0] data_i,
  output logic                 word_done_o,
  output logic                 last_word_o,
  output logic                 wr_o,
  output logic [ADDR_W-1:0]    waddr_o,
  output logic [INSTR_W-1:0]   wdata_o
);

  logic [1:0]           qcnt_q;
  logic [QUINTET_W-1:0] q0_q;
  logic [QUINTET_W-1:0] q1_q;
  logic [ADDR_W-1:0]    word_q;
  logic                 wr_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic [INSTR_W-1:0]   wdata_q;

  assign word_done_o = acc_i & (qcnt_q == 2'd2);
  assign last_word_o = (word_q == ADDR_W'(IMEM_WORDS - 1));
  assign wr_o        = wr_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_q  <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= word_done_o;
      if (clr_i) begin
        qcnt_q <= '0;
        word_q <= '0;
      end else if (acc_i) begin
        case (qcnt_q)
          2'd0: begin
            q0_q   <= data_i;
            qcnt_q <= 2'd1;
          end
          2'd1: begin
            q1_q   <= data_i;
            qcnt_q <= 2'd2;
          end
          default: begin
            qcnt_q  <= '0;
            word_q  <= word_q + 1'b1;
            waddr_q <= word_q;
            wdata_q <= {data_i, q1_q, q0_q};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Boot loader and run control for the tiny SoC CPU.
// Loads 8 words, then gates cpu_en with run/halt/step/breakpoint.
module cpu_run_controller
  import tinysoc_pkg::*;
#(
  parameter bit AUTORUN = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [QUINTET_W-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 imem_wr,
  output logic [ADDR_W-1:0]    imem_waddr,
  output logic [INSTR_W-1:0]   imem_wdata,
  input  logic [ADDR_W-1:0]    pc,
  output logic                 cpu_en,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 reload_req,
  input  logic                 bp_en,
  input  logic [ADDR_W-1:0]    bp_addr,
  output logic                 halted,
  output logic                 loaded,
  output logic [CNT_W-1:0]     retired
);

  state_e           state_q;
  logic             skip_q;
  logic             halted_q;
  logic             loaded_q;
  logic [CNT_W-1:0] retired_q;

  logic accept;
  logic reload;
  logic word_done;
  logic last_word;
  logic bp_hit;

  assign load_ready = (state_q == ST_LOAD);
  assign accept     = load_valid & load_ready;
  assign reload     = (state_q == ST_HALT) & reload_req;
  assign bp_hit     = bp_en & (pc == bp_addr) & ~skip_q;
  assign cpu_en     = ((state_q == ST_RUN) & ~bp_hit)
                    | (state_q == ST_STEP);

  assign halted  = halted_q;
  assign loaded  = loaded_q;
  assign retired = retired_q;

  quintet_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (reload),
    .acc_i       (accept),
    .data_i      (load_data),
    .word_done_o (word_done),
    .last_word_o (last_word),
    .wr_o        (imem_wr),
    .waddr_o     (imem_waddr),
    .wdata_o     (imem_wdata)
  );

  // skip lets a resume at the breakpoint PC execute it once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      skip_q    <= 1'b0;
      halted_q  <= 1'b0;
      loaded_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (cpu_en) begin
        retired_q <= retired_q + 1'b1;
        skip_q    <= 1'b0;
      end
      unique case (state_q)
        ST_LOAD: begin
          if (word_done & last_word)
            state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          loaded_q <= 1'b1;
          state_q  <= AUTORUN ? ST_RUN : ST_HALT;
          halted_q <= ~AUTORUN;
        end
        ST_RUN: begin
          if (halt_req | bp_hit) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (reload_req) begin
            state_q   <= ST_LOAD;
            halted_q  <= 1'b0;
            loaded_q  <= 1'b0;
            retired_q <= '0;
          end else if (step_req) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
            skip_q   <= 1'b1;
          end else if (run_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            skip_q   <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_LOAD;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
